// File: rtl/swerv_axi_wr_arb.sv
// N-master to 1-slave AXI4 write-channel arbiter: round-robin AW grant with ID prefixing,
// in-order W steering through a route FIFO, and B return routing by ID prefix.
module swerv_axi_wr_arb #(
  parameter int NM       = 3,
  parameter int IDW      = 4,
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int WQ_DEPTH = 4,
  localparam int IW      = $clog2(NM),
  localparam int AWP     = IDW + AW + 16,
  localparam int WP      = DW + DW / 8 + 1
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  bus_clk_en,
  input  logic [NM-1:0]         s_awvalid,
  output logic [NM-1:0]         s_awready,
  input  logic [NM*AWP-1:0]     s_aw,
  input  logic [NM-1:0]         s_wvalid,
  output logic [NM-1:0]         s_wready,
  input  logic [NM*WP-1:0]      s_w,
  output logic [NM-1:0]         s_bvalid,
  input  logic [NM-1:0]         s_bready,
  output logic [IDW+1:0]        s_b,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [AWP+IW-1:0]     m_aw,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [WP-1:0]         m_w,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [IDW+IW+1:0]     m_b,
  output logic                  wq_full
);

  // Handshake rule on every channel: a beat transfers on a clock edge where valid, ready
  // and bus_clk_en are all 1; a valid, once raised, holds its payload until that happens.

  localparam int PW = $clog2(WQ_DEPTH);
  localparam int CW = $clog2(WQ_DEPTH + 1);

  // Reset also masks the combinational paths so nothing handshakes while rst_l is low.
  logic en;
  assign en = bus_clk_en & rst_l;

  // ---------------- AW arbitration ----------------
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  win;
  logic           any_aw;
  logic [AWP-1:0] aw_sel;
  logic           aw_accept;
  logic           aw_fire;
  logic [CW-1:0]  wq_count;

  always_comb begin
    win    = '0;
    any_aw = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      for (int j = 0; j < NM; j++) begin
        if (!any_aw && (j == (int'(rr_ptr) + k) % NM) && s_awvalid[j]) begin
          any_aw = 1'b1;
          win    = IW'(j);
        end
      end
    end
  end

  always_comb begin
    aw_sel = '0;
    for (int j = 0; j < NM; j++) begin
      if (win == IW'(j)) aw_sel = s_aw[j*AWP +: AWP];
    end
  end

  assign aw_accept = en & (~m_awvalid | m_awready) & (wq_count < CW'(WQ_DEPTH));
  assign aw_fire   = aw_accept & any_aw;

  always_comb begin
    s_awready = '0;
    for (int j = 0; j < NM; j++) begin
      s_awready[j] = aw_fire & (win == IW'(j));
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_awvalid <= 1'b0;
      m_aw      <= '0;
      rr_ptr    <= IW'(NM - 1);
    end else if (aw_fire) begin
      m_awvalid <= 1'b1;
      m_aw      <= {win, aw_sel};
      rr_ptr    <= win;
    end else if (en && m_awready) begin
      m_awvalid <= 1'b0;
    end
  end

  // ---------------- Route FIFO: master index per accepted AW ----------------
  logic [IW-1:0] wq_mem [WQ_DEPTH];
  logic [PW-1:0] wq_wr;
  logic [PW-1:0] wq_rd;
  logic [IW-1:0] wq_head;
  logic          wq_empty;
  logic          wq_pop;

  assign wq_head  = wq_mem[wq_rd];
  assign wq_empty = (wq_count == '0);
  assign wq_full  = (wq_count == CW'(WQ_DEPTH));

  always_ff @(posedge clk) begin
    if (aw_fire) wq_mem[wq_wr] <= win;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wq_wr    <= '0;
      wq_rd    <= '0;
      wq_count <= '0;
    end else begin
      if (aw_fire) wq_wr <= wq_wr + PW'(1);
      if (wq_pop)  wq_rd <= wq_rd + PW'(1);
      if (aw_fire && !wq_pop)      wq_count <= wq_count + CW'(1);
      else if (wq_pop && !aw_fire) wq_count <= wq_count - CW'(1);
    end
  end

  // ---------------- W steering: only the FIFO head master may send ----------------
  always_comb begin
    m_wvalid = 1'b0;
    m_w      = '0;
    s_wready = '0;
    for (int j = 0; j < NM; j++) begin
      if (!wq_empty && (wq_head == IW'(j))) begin
        m_wvalid    = s_wvalid[j] & en;
        m_w         = s_w[j*WP +: WP];
        s_wready[j] = m_wready & en;
      end
    end
  end

  // Bit 0 of the W payload is last; the route entry retires with the final beat.
  assign wq_pop = m_wvalid & m_wready & m_w[0];

  // ---------------- B return by ID prefix ----------------
  logic [IW-1:0] b_idx;
  assign b_idx = m_b[IDW+IW+1:IDW+2];
  assign s_b   = m_b[IDW+1:0];

  // Default m_bready=en sinks responses whose prefix names no master.
  always_comb begin
    s_bvalid = '0;
    m_bready = en;
    for (int j = 0; j < NM; j++) begin
      if (b_idx == IW'(j)) begin
        s_bvalid[j] = m_bvalid & en;
        m_bready    = s_bready[j] & en;
      end
    end
  end

endmodule
